// File: rtl/cast5_pkg.sv
// Shared constants and types for the CAST5 S-box bank arbiter.
package cast5_pkg;

  // Owner encoding equals the table-select value driven for that owner.
  localparam logic OWNER_KE = 1'b0;
  localparam logic OWNER_DP = 1'b1;

  localparam int unsigned SBOX_AW = 32;
  localparam int unsigned SBOX_DW = 128;

  // One in-flight lookup: whether it exists and who issued it.
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/cast5_sbox_tagpipe.sv
// Tag shift register tracking in-flight ROM lookups: a tag pushed at cycle t
// appears on the tail at t+DEPTH. Synchronous clear drops everything in flight.
module cast5_sbox_tagpipe
  import cast5_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t push,
  output tag_t tail,
  output logic busy
);

  tag_t stage_q [DEPTH];

  // Shift tags one stage per cycle; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= push;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  // Tail tag and OR of all valid bits.
  always_comb begin
    tail = stage_q[DEPTH-1];
    busy = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      busy = busy | stage_q[k].valid;
    end
  end

endmodule

// File: rtl/cast5_sbox_arb.sv
// Arbiter for the shared CAST5 S-box ROM bank between key expansion (S5-8)
// and the round datapath (S1-4). One lookup granted per cycle; results are
// routed back to the issuer RD_LAT cycles later via a tag pipeline.
module cast5_sbox_arb
  import cast5_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ke_req,
  input  logic               i_ke_lock,
  input  logic [SBOX_AW-1:0] i_ke_addr,
  output logic               o_ke_gnt,
  output logic               o_ke_rvalid,
  input  logic               i_dp_req,
  input  logic [SBOX_AW-1:0] i_dp_addr,
  output logic               o_dp_gnt,
  output logic               o_dp_rvalid,
  output logic [SBOX_DW-1:0] o_rdata,
  output logic [SBOX_AW-1:0] o_sbox_addr,
  output logic               o_sbox_sel,
  input  logic [SBOX_DW-1:0] i_sbox_dout,
  output logic               o_busy
);

  localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [SBOX_AW-1:0] addr_q, addr_d;
  tag_t               tag_push, tag_tail;
  logic               pipe_busy;

  // Grant decision: lock gives KE exclusive use; otherwise KE wins ties
  // until DP has watched STARVE_MAX consecutive KE grants.
  always_comb begin
    o_ke_gnt = 1'b0;
    o_dp_gnt = 1'b0;
    if (!i_rst) begin
      if (i_ke_lock) begin
        o_ke_gnt = i_ke_req;
      end else if (i_ke_req && i_dp_req) begin
        if (starve_q == STARVE_LIM) begin
          o_dp_gnt = 1'b1;
        end else begin
          o_ke_gnt = 1'b1;
        end
      end else begin
        o_ke_gnt = i_ke_req;
        o_dp_gnt = i_dp_req;
      end
    end
  end

  // Starve counter next state: counts KE grants while DP is kept waiting.
  always_comb begin
    starve_d = starve_q;
    if (i_ke_lock || !i_dp_req || o_dp_gnt) begin
      starve_d = '0;
    end else if (o_ke_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // ROM address/select: follow the granted requester; idle keeps the address
  // stable and parks select high so the ROMs do not toggle.
  always_comb begin
    o_sbox_addr = addr_q;
    o_sbox_sel  = OWNER_DP;
    if (i_rst) begin
      o_sbox_addr = '0;
    end else if (o_ke_gnt) begin
      o_sbox_addr = i_ke_addr;
      o_sbox_sel  = OWNER_KE;
    end else if (o_dp_gnt) begin
      o_sbox_addr = i_dp_addr;
    end
    addr_d = o_sbox_addr;
  end

  // State registers for the starve counter and held ROM address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q <= '0;
      addr_q   <= '0;
    end else begin
      starve_q <= starve_d;
      addr_q   <= addr_d;
    end
  end

  // Tag entering the pipeline this cycle.
  always_comb begin
    tag_push.valid = o_ke_gnt | o_dp_gnt;
    tag_push.owner = o_dp_gnt ? OWNER_DP : OWNER_KE;
  end

  cast5_sbox_tagpipe #(
    .DEPTH (RD_LAT)
  ) u_tagpipe (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (tag_push),
    .tail (tag_tail),
    .busy (pipe_busy)
  );

  // Response routing; outputs are forced quiet while reset is asserted.
  always_comb begin
    o_rdata     = i_sbox_dout;
    o_ke_rvalid = !i_rst && tag_tail.valid && (tag_tail.owner == OWNER_KE);
    o_dp_rvalid = !i_rst && tag_tail.valid && (tag_tail.owner == OWNER_DP);
    o_busy      = !i_rst && pipe_busy;
  end

endmodule

// File: tb/tb_cast5_sbox_arb.sv
// Scoreboard bench for cast5_sbox_arb: two instances (RD_LAT=1 and RD_LAT=3)
// share one stimulus stream; each has its own ROM model.
module tb_cast5_sbox_arb;
  import cast5_pkg::*;

  localparam int SMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, lock, ke_req, dp_req;
  logic [31:0] ke_addr, dp_addr;
  logic [1:0]  ke_gnt, dp_gnt, ke_rv, dp_rv, sel, busy;
  logic [31:0] saddr [2];
  logic [127:0] rdata [2];
  logic [127:0] dout [2];

  cast5_sbox_arb #(.RD_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_ke_req(ke_req), .i_ke_lock(lock), .i_ke_addr(ke_addr),
    .o_ke_gnt(ke_gnt[0]), .o_ke_rvalid(ke_rv[0]), .i_dp_req(dp_req), .i_dp_addr(dp_addr),
    .o_dp_gnt(dp_gnt[0]), .o_dp_rvalid(dp_rv[0]), .o_rdata(rdata[0]),
    .o_sbox_addr(saddr[0]), .o_sbox_sel(sel[0]), .i_sbox_dout(dout[0]), .o_busy(busy[0])
  );

  cast5_sbox_arb #(.RD_LAT(3), .STARVE_MAX(SMAX)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_ke_req(ke_req), .i_ke_lock(lock), .i_ke_addr(ke_addr),
    .o_ke_gnt(ke_gnt[1]), .o_ke_rvalid(ke_rv[1]), .i_dp_req(dp_req), .i_dp_addr(dp_addr),
    .o_dp_gnt(dp_gnt[1]), .o_dp_rvalid(dp_rv[1]), .o_rdata(rdata[1]),
    .o_sbox_addr(saddr[1]), .o_sbox_sel(sel[1]), .i_sbox_dout(dout[1]), .o_busy(busy[1])
  );

  // Stand-in S-box contents: table set 1 (S1-4) or 0 (S5-8), ROM k indexed by byte k.
  function automatic logic [127:0] rom_lookup(input logic dp_tbl, input logic [31:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      r[32*k +: 32] = (32'(a[8*k +: 8]) + 32'(k) * 32'h100 + (dp_tbl ? 32'h1_0000 : 32'h0)
                       + 32'h1) * 32'h9E37_79B1;
    end
    return r;
  endfunction

  // ROM bank models with 1- and 3-cycle read latency.
  logic [32:0] rom1_q;
  logic [32:0] rom3_q [3];
  always @(posedge clk) begin
    rom1_q    <= {sel[0], saddr[0]};
    rom3_q[0] <= {sel[1], saddr[1]};
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign dout[0] = rom_lookup(rom1_q[32], rom1_q[31:0]);
  assign dout[1] = rom_lookup(rom3_q[2][32], rom3_q[2][31:0]);

  typedef struct {
    int           due;
    logic [1:0]   rv;    // {ke, dp}
    logic [127:0] data;
  } exp_t;

  exp_t        sb [2][$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          run_len = 0;     // KE grants DP has sat through since it was last served
  logic [31:0] last_addr = '0;
  int          ke_tot = 0;
  int          dp_tot = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: reference model of grants plus per-instance response scoreboard.
  initial begin
    logic        xk, xd;
    logic [31:0] xa;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("rst_gnt%0d", i), {ke_gnt[i], dp_gnt[i]}, 2'b00);
          chk($sformatf("rst_rvalid%0d", i), {ke_rv[i], dp_rv[i]}, 2'b00);
          chk($sformatf("rst_sel%0d", i), sel[i], 1'b1);
          chk($sformatf("rst_addr%0d", i), saddr[i], 32'h0);
          chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
          sb[i].delete();
        end
        run_len   = 0;
        last_addr = '0;
      end else begin
        xk = ke_req && (lock || !dp_req || run_len != SMAX);
        xd = dp_req && !lock && !xk;
        xa = xk ? ke_addr : (xd ? dp_addr : last_addr);
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("busy%0d", i), busy[i], sb[i].size() > 0);
          if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
            e = sb[i].pop_front();
            chk($sformatf("rvalid%0d", i), {ke_rv[i], dp_rv[i]}, e.rv);
            chk($sformatf("rdata%0d", i), rdata[i], e.data);
          end else begin
            chk($sformatf("idle_rvalid%0d", i), {ke_rv[i], dp_rv[i]}, 2'b00);
          end
          chk($sformatf("gnt%0d", i), {ke_gnt[i], dp_gnt[i]}, {xk, xd});
          chk($sformatf("sbox_addr%0d", i), saddr[i], xa);
          chk($sformatf("sbox_sel%0d", i), sel[i], !xk);
          if (xk || xd) begin
            e.due  = cyc + (i == 0 ? 1 : 3);
            e.rv   = {xk, xd};
            e.data = rom_lookup(xd, xa);
            sb[i].push_back(e);
          end
        end
        if (lock || !dp_req || xd) run_len = 0;
        else if (xk && run_len < SMAX) run_len++;
        if (xk || xd) last_addr = xa;
        if (xk) ke_tot++;
        if (xd) dp_tot++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic kr, input logic dr,
                       input logic [31:0] ka, input logic [31:0] da);
    rst = r; lock = l; ke_req = kr; dp_req = dr; ke_addr = ka; dp_addr = da;
  endtask

  initial begin
    int k0, d0;
    // Reset with both requests pending, then KE wins the first free cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
    step();

    // Lock: KE owns the bank.
    k0 = ke_tot; d0 = dp_tot;
    repeat (40) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
      step();
    end
    chk("lock_ke_grants", ke_tot - k0, 40);
    chk("lock_dp_grants", dp_tot - d0, 0);

    // Starvation: KE x8, DP x1, repeating.
    k0 = ke_tot; d0 = dp_tot;
    repeat (36) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
      step();
    end
    chk("starve_ke_grants", ke_tot - k0, 32);
    chk("starve_dp_grants", dp_tot - d0, 4);

    // Routing: alternating owners, back to back.
    for (int n = 0; n < 20; n++) begin
      drive(1'b0, 1'b0, n % 2 == 0, n % 2 == 1, 32'h0102_0304, 32'hA0B1_C2D3);
      step();
    end

    // Lock rises one cycle after a DP grant.
    d0 = dp_tot;
    drive(1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
    step();
    repeat (6) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
      step();
    end
    chk("lock_edge_dp_grants", dp_tot - d0, 1);

    // Reset while a lookup is in flight.
    drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom, $urandom);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    step();
    repeat (5) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      step();
    end

    // Random traffic, including occasional reset and lock toggling.
    repeat (400) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom);
      step();
    end

    // Drain and confirm every expected response arrived.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int w = 0; w < 10 && (sb[0].size() != 0 || sb[1].size() != 0); w++) step();
    step();
    chk("drain_lat1", sb[0].size(), 0);
    chk("drain_lat3", sb[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
